// File: rtl/viterbi_mmu_pkg.sv
// viterbi_mmu_pkg: shared widths, types and the RAM address helper for the
// Viterbi survivor-memory manager.
//   - Build option MMU_BYPASS_EN (see viterbi_mmu_ram) changes same-cycle
//     read/write collision behaviour of the survivor RAM.
package viterbi_mmu_pkg;
  localparam int WD_DEPTH       = 6;                     // page address width
  localparam int WD_FSM         = 6;                     // state-index width
  localparam int N_ACS          = 4;                     // survivor bits per step
  localparam int WD_TB_ADDRESS  = 5;                     // traceback segment width
  localparam int WD_RAM_DATA    = 2 * N_ACS;             // two nibbles per word
  localparam int WD_RAM_ADDRESS = WD_DEPTH + WD_FSM - 1; // {page, segment}
  localparam int RAM_DEPTH      = 1 << WD_RAM_ADDRESS;

  typedef logic [WD_DEPTH-1:0]       page_t;
  typedef logic [WD_FSM-2:0]         seg_t;
  typedef logic [WD_TB_ADDRESS-1:0]  tbseg_t;
  typedef logic [N_ACS-1:0]          surv_t;
  typedef logic [WD_RAM_ADDRESS-1:0] ram_addr_t;
  typedef logic [WD_RAM_DATA-1:0]    ram_data_t;

  typedef struct packed {
    logic      we;
    ram_addr_t addr;
    ram_data_t data;
  } ram_wr_t;

  // Page is the high field, segment the low field.
  function automatic ram_addr_t mk_addr(page_t page, seg_t seg);
    return {page, seg};
  endfunction
endpackage

// File: rtl/viterbi_mmu_if.sv
// viterbi_mmu_if: phase, control and data signals between the ACS array /
// traceback unit (master) and the survivor-memory manager (slave).
//   master drives Clock1/Clock2 phases, Active/Hold/Init, ACSPage,
//   ACSSegment_minusLSB, Survivors, AddressTB; slave returns DataTB.
interface viterbi_mmu_if;
  import viterbi_mmu_pkg::*;

  logic      Clock1;
  logic      Clock2;
  logic      Active;
  logic      Hold;
  logic      Init;
  page_t     ACSPage;
  seg_t      ACSSegment_minusLSB;
  surv_t     Survivors;
  tbseg_t    AddressTB;
  ram_data_t DataTB;

  modport master (
    output Clock1, Clock2, Active, Hold, Init,
    output ACSPage, ACSSegment_minusLSB, Survivors, AddressTB,
    input  DataTB
  );

  modport slave (
    input  Clock1, Clock2, Active, Hold, Init,
    input  ACSPage, ACSSegment_minusLSB, Survivors, AddressTB,
    output DataTB
  );
endinterface

// File: rtl/viterbi_mmu_ram.sv
// viterbi_mmu_ram: 2048x8 survivor RAM, one synchronous write port and one
// synchronous read port with a registered, resettable read-data output.
//   clk, rst    : system clock, async active-high reset (read register only)
//   wr_i        : write request {we, addr, data}
//   rd_en_i     : load read register this cycle
//   rd_addr_i   : read address
//   rd_data_o   : registered read data, holds when rd_en_i is low
// Build option MMU_BYPASS_EN: a read of the address being written in the
// same cycle returns the new byte; otherwise the old byte is returned.
module viterbi_mmu_ram
  import viterbi_mmu_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  ram_wr_t   wr_i,
  input  logic      rd_en_i,
  input  ram_addr_t rd_addr_i,
  output ram_data_t rd_data_o
);
  ram_data_t mem_q [RAM_DEPTH];
  ram_data_t rd_word;
  ram_data_t rd_data_q;

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_i.we) mem_q[wr_i.addr] <= wr_i.data;
  end

`ifdef MMU_BYPASS_EN
  assign rd_word = (wr_i.we && (wr_i.addr == rd_addr_i)) ? wr_i.data : mem_q[rd_addr_i];
`else
  assign rd_word = mem_q[rd_addr_i];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= rd_word;
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/viterbi_mmu.sv
// viterbi_mmu: survivor-memory manager between the ACS array and the
// traceback unit. Packs survivor nibbles into bytes, writes them at
// {ACSPage, ACSSegment_minusLSB}, and serves traceback reads at
// {TBPage, AddressTB}.
//   CLOCK : system clock (all logic on rising edge)
//   Reset : async active-high reset
//   bus   : viterbi_mmu_if.slave (Clock1/Clock2 phase levels, Active, Hold,
//           Init, ACSPage, ACSSegment_minusLSB, Survivors, AddressTB, DataTB)
// Build option MMU_BYPASS_EN: forwarded in viterbi_mmu_ram.
module viterbi_mmu
  import viterbi_mmu_pkg::*;
(
  input  logic CLOCK,
  input  logic Reset,
  viterbi_mmu_if.slave bus
);
  // Clock1/Clock2 are phase levels sampled on CLOCK, not clocks.
  logic c1_q, c2_q;
  logic c1r, c1f, c2r, c2f;

  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) begin
      c1_q <= 1'b0;
      c2_q <= 1'b0;
    end else begin
      c1_q <= bus.Clock1;
      c2_q <= bus.Clock2;
    end
  end

  assign c1r = bus.Clock1 & ~c1_q;
  assign c1f = ~bus.Clock1 & c1_q;
  assign c2r = bus.Clock2 & ~c2_q;
  assign c2f = ~bus.Clock2 & c2_q;

  // Only the Clock2 rise drives behaviour; the other events are kept for
  // observability and future sequencing.
  logic unused_phase;
  assign unused_phase = ^{c1r, c1f, c2f};

  logic capture, rd_en;
  assign capture = c2r & bus.Active & ~bus.Hold;
  assign rd_en   = c2r & bus.Active;

  // Nibble shifter and write staging: the write lands one CLOCK after capture.
  ram_data_t buf_q, buf_d;
  ram_addr_t wr_addr_q, wr_addr_d;
  logic      wr_pend_q, wr_pend_d;

  always_comb begin
    buf_d     = buf_q;
    wr_addr_d = wr_addr_q;
    wr_pend_d = 1'b0;
    if (capture) begin
      // Newest nibble enters the high half, so A then B stores {B,A}.
      buf_d     = {bus.Survivors, buf_q[WD_RAM_DATA-1:N_ACS]};
      wr_addr_d = mk_addr(bus.ACSPage, bus.ACSSegment_minusLSB);
      wr_pend_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) begin
      buf_q     <= '0;
      wr_addr_q <= '0;
      wr_pend_q <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      wr_addr_q <= wr_addr_d;
      wr_pend_q <= wr_pend_d;
    end
  end

  // Traceback page: Init beats Hold, and Init works even while inactive.
  page_t tb_page_q, tb_page_d;

  always_comb begin
    tb_page_d = tb_page_q;
    if (c2r) begin
      if (bus.Init)                      tb_page_d = bus.ACSPage - page_t'(1);
      else if (bus.Hold && bus.Active)   tb_page_d = tb_page_q - page_t'(1);
    end
  end

  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) tb_page_q <= '0;
    else       tb_page_q <= tb_page_d;
  end

  ram_wr_t   ram_wr;
  ram_data_t rd_data;

  assign ram_wr = '{we: wr_pend_q, addr: wr_addr_q, data: buf_q};

  // Read address uses the page as registered before this edge.
  viterbi_mmu_ram u_ram (
    .clk       (CLOCK),
    .rst       (Reset),
    .wr_i      (ram_wr),
    .rd_en_i   (rd_en),
    .rd_addr_i (mk_addr(tb_page_q, bus.AddressTB)),
    .rd_data_o (rd_data)
  );

  assign bus.DataTB = rd_data;
endmodule

// File: tb/tb_viterbi_mmu.sv
module tb_viterbi_mmu;
  import viterbi_mmu_pkg::*;

  logic CLOCK = 1'b0;
  logic Reset = 1'b1;
  always #10 CLOCK = ~CLOCK;

  viterbi_mmu_if bus();

  viterbi_mmu dut (
    .CLOCK (CLOCK),
    .Reset (Reset),
    .bus   (bus)
  );

  // Stand-alone RAM for the same-cycle collision case, which the top-level
  // phase sequencing never produces.
  ram_wr_t   r_wr;
  logic      r_re;
  ram_addr_t r_raddr;
  ram_data_t r_rdata;

  viterbi_mmu_ram u_ram (
    .clk       (CLOCK),
    .rst       (Reset),
    .wr_i      (r_wr),
    .rd_en_i   (r_re),
    .rd_addr_i (r_raddr),
    .rd_data_o (r_rdata)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Reference model: transaction level, one event per Clock2 rise.
  logic [7:0] m_mem [2048];
  bit         m_known [2048];
  logic [7:0] m_buf;
  int         m_tb;
  logic [7:0] m_data;
  bit         m_data_known;
  bit         pend;
  int         p_addr;
  logic [7:0] p_data;

  task automatic model_reset();
    m_buf = 8'h00; m_tb = 0; m_data = 8'h00; m_data_known = 1; pend = 0;
  endtask

  task automatic tick();
    @(posedge CLOCK); #1;
  endtask

  // One full phase cycle: C1 rise, C2 rise, C1 fall, C2 fall.
  task automatic quad(input bit act, input bit hold, input bit init,
                      input int page, input int seg, input logic [3:0] surv,
                      input int atb, input bit rst_mid);
    bus.Active = act; bus.Hold = hold; bus.Init = init;
    bus.ACSPage = page_t'(page); bus.ACSSegment_minusLSB = seg_t'(seg);
    bus.Survivors = surv; bus.AddressTB = tbseg_t'(atb);
    bus.Clock1 = 1'b1; tick();
    bus.Clock2 = 1'b1; tick();
    if (act) begin
      m_data       = m_mem[m_tb*32 + atb];
      m_data_known = m_known[m_tb*32 + atb];
    end
    if (act && !hold) begin
      m_buf  = {surv, m_buf[7:4]};
      p_addr = page*32 + seg;
      p_data = m_buf;
      pend   = 1;
    end
    if (init)             m_tb = (page + 63) % 64;
    else if (hold && act) m_tb = (m_tb + 63) % 64;
    if (m_data_known) chk("rd", {24'd0, bus.DataTB}, {24'd0, m_data});
    if (rst_mid) begin
      Reset = 1'b1; #1;
      model_reset();
      chk("rst_data", {24'd0, bus.DataTB}, 32'd0);
      bus.Clock1 = 1'b0; bus.Clock2 = 1'b0;
      tick(); tick();
      Reset = 1'b0;
      tick();
      return;
    end
    bus.Clock1 = 1'b0; tick();
    if (pend) begin
      m_mem[p_addr] = p_data; m_known[p_addr] = 1; pend = 0;
    end
    bus.Clock2 = 1'b0; tick();
    if (m_data_known) chk("hold", {24'd0, bus.DataTB}, {24'd0, m_data});
  endtask

  task automatic wr_pair(input int page, input int seg, input logic [3:0] a, input logic [3:0] b);
    quad(1, 0, 0, page, seg, a, 0, 0);
    quad(1, 0, 0, page, seg, b, 0, 0);
  endtask

  logic [7:0] saved;

  initial begin
    for (int i = 0; i < 2048; i++) begin m_known[i] = 0; m_mem[i] = 8'h00; end
    bus.Clock1 = 0; bus.Clock2 = 0; bus.Active = 0; bus.Hold = 0; bus.Init = 0;
    bus.ACSPage = '0; bus.ACSSegment_minusLSB = '0; bus.Survivors = '0; bus.AddressTB = '0;
    r_wr = '{we: 1'b0, addr: '0, data: '0}; r_re = 0; r_raddr = '0;
    model_reset();
    tick(); tick();
    chk("reset_data", {24'd0, bus.DataTB}, 32'd0);
    Reset = 1'b0;
    tick();

    // 1: write A,B to page 2 seg 0, Init to page 3, read back 0xBA
    wr_pair(2, 0, 4'hA, 4'hB);
    tick(); tick(); tick();
    quad(1, 1, 1, 3, 0, 4'h0, 0, 0);
    quad(1, 1, 0, 10, 9, 4'h0, 0, 0);
    chk("t1_BA", {24'd0, bus.DataTB}, 32'hBA);

    // 2: page wrap 0 - 1 = 63
    wr_pair(63, 31, 4'h7, 4'h3);
    quad(1, 1, 1, 0, 0, 4'h0, 31, 0);
    quad(1, 1, 0, 0, 0, 4'h0, 31, 0);
    chk("t2_wrap", {24'd0, bus.DataTB}, 32'h37);

    // 3: Hold steps the traceback page down
    wr_pair(3, 1, 4'h6, 4'h9);
    wr_pair(4, 1, 4'h1, 4'h2);
    quad(1, 1, 1, 5, 0, 4'h0, 1, 0);
    quad(1, 1, 0, 0, 0, 4'h0, 1, 0);
    chk("t3_pg4", {24'd0, bus.DataTB}, 32'h21);
    quad(1, 1, 0, 0, 0, 4'h0, 1, 0);
    chk("t3_pg3", {24'd0, bus.DataTB}, 32'h96);

    // 4: Active=0 freezes writes and reads; Init still acts
    wr_pair(7, 2, 4'h4, 4'hE);
    saved = m_data;
    quad(0, 0, 0, 7, 2, 4'hF, 2, 0);
    quad(0, 0, 0, 7, 2, 4'hD, 2, 0);
    quad(0, 0, 1, 8, 2, 4'hC, 2, 0);
    chk("t4_hold", {24'd0, bus.DataTB}, {24'd0, saved});
    quad(1, 1, 0, 0, 0, 4'h0, 2, 0);
    chk("t4_ram", {24'd0, bus.DataTB}, 32'hE4);

    // 5: reset mid-write discards the pending write, clears TBPage
    wr_pair(0, 3, 4'h1, 4'h2);
    quad(1, 0, 1, 9, 5, 4'h0, 0, 0);
    quad(1, 0, 0, 0, 3, 4'hF, 0, 1);
    quad(1, 1, 0, 0, 0, 4'h0, 3, 0);
    chk("t5_discard", {24'd0, bus.DataTB}, 32'h21);
    wr_pair(20, 4, 4'hC, 4'h5);
    quad(1, 1, 1, 21, 0, 4'h0, 4, 0);
    quad(1, 1, 0, 0, 0, 4'h0, 4, 0);
    chk("t5_5C", {24'd0, bus.DataTB}, 32'h5C);

    // Randomized traffic over a small address window
    for (int k = 0; k < 300; k++) begin
      quad(($urandom % 5) != 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
           $urandom_range(0, 4), $urandom_range(0, 3), 4'($urandom),
           $urandom_range(0, 3), 0);
    end

    // 6: same-cycle read/write collision at the RAM
    r_wr = '{we: 1'b1, addr: ram_addr_t'(5), data: 8'h11};
    tick();
    r_wr.data = 8'h22; r_re = 1'b1; r_raddr = ram_addr_t'(5);
    tick();
`ifdef MMU_BYPASS_EN
    chk("t6_coll", {24'd0, r_rdata}, 32'h22);
`else
    chk("t6_coll", {24'd0, r_rdata}, 32'h11);
`endif
    r_wr.we = 1'b0;
    tick();
    chk("t6_after", {24'd0, r_rdata}, 32'h22);
    r_re = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
